// File: rtl/instr_encoder_if.sv
// Handshake bundle between an instruction source, the encoder and the memory-image sink.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [15:0] in_immed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic [15:0] out_addr;
    logic        err;

    modport master (
        output in_valid, in_op, in_immed, out_ready,
        input  in_ready, out_valid, out_word, out_addr, err
    );

    modport slave (
        input  in_valid, in_op, in_immed, out_ready,
        output in_ready, out_valid, out_word, out_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: turns {opcode, immediate} into fetchable 16-bit words,
// inserting a Pre word ahead of prefixable ops whose immediate exceeds 12 bits.
module instr_encoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic clk,
    input  logic reset,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, PRE, MAIN} state_t;

    state_t      state;
    logic [15:0] pending;
    logic [15:0] word_q;
    logic [15:0] addr_q;
    logic        valid_q;
    logic        err_q;

    logic [3:0]  hi;
    logic [3:0]  lo;
    logic [3:0]  ext;
    logic        is_class0;
    logic        is_imm;
    logic        is_prefixable;
    logic        is_trunc_op;
    logic        legal;
    logic        needs_pre;
    logic        trunc_err;
    logic [15:0] main_word;
    logic [15:0] pre_word;
    logic        accept;
    logic        handshake;

    always_comb begin
        hi            = bus.in_op[7:4];
        lo            = bus.in_op[3:0];
        ext           = bus.in_immed[15:12];
        is_class0     = (hi == 4'h0) && (lo <= 4'hc);
        is_imm        = 1'b0;
        is_prefixable = 1'b0;
        is_trunc_op   = 1'b0;
        // Push/Call/Jump/JumpF/JumpT can be extended by a Pre word; Get/Put/Pop/Pre cannot.
        if (lo == 4'h0) begin
            case (hi)
                4'h1, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    is_imm        = 1'b1;
                    is_prefixable = 1'b1;
                end
                4'h8, 4'h9, 4'ha, 4'hb: begin
                    is_imm      = 1'b1;
                    is_trunc_op = 1'b1;
                end
                default: ;
            endcase
        end
        legal     = is_class0 || is_imm;
        needs_pre = is_prefixable && (ext != 4'h0);
        trunc_err = is_trunc_op && (ext != 4'h0);
        main_word = is_class0 ? {12'h000, lo} : {hi, bus.in_immed[11:0]};
        pre_word  = {4'hb, 8'h00, ext};
    end

    assign bus.in_ready  = (state == EMPTY) || ((state == MAIN) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign handshake     = valid_q && bus.out_ready;

    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            pending <= 16'h0000;
            word_q  <= 16'h0000;
            addr_q  <= BASE_ADDR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (handshake) begin
                addr_q <= addr_q + 16'h0001;
            end
            case (state)
                EMPTY, MAIN: begin
                    if (accept) begin
                        if (!legal) begin
                            // Illegal ops are swallowed: nothing emitted, address untouched.
                            err_q   <= 1'b1;
                            state   <= EMPTY;
                            valid_q <= 1'b0;
                        end else if (needs_pre) begin
                            word_q  <= pre_word;
                            pending <= main_word;
                            state   <= PRE;
                            valid_q <= 1'b1;
                        end else begin
                            word_q  <= main_word;
                            err_q   <= trunc_err;
                            state   <= MAIN;
                            valid_q <= 1'b1;
                        end
                    end else if ((state == MAIN) && bus.out_ready) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                PRE: begin
                    if (bus.out_ready) begin
                        word_q <= pending;
                        state  <= MAIN;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven vectors with a word/address scoreboard
// plus hand-written stall, reset-in-PRE and address-wrap sequences.
module tb_instr_encoder;
    logic clk;
    logic reset;

    instr_encoder_if bus0();
    instr_encoder_if bus1();

    instr_encoder #(.BASE_ADDR(16'h0000)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    instr_encoder #(.BASE_ADDR(16'hfffe)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [7:0]  op;
        logic [15:0] immed;
        bit          err;
        int          nwords;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic [15:0] addr;
    } exp_t;

    vec_t        vecs[18];
    exp_t        sb[$];
    logic [15:0] exp_addr;
    bit          exp_err;
    bit          mon_en;
    bit          rand_ready;
    bit          prev_stall;
    logic [15:0] prev_word;
    logic [15:0] prev_addr;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] immed, input bit e,
                                 input int n, input logic [15:0] w0, input logic [15:0] w1);
        bit accepted;
        accepted        = 1'b0;
        bus0.in_valid   = 1'b1;
        bus0.in_op      = op;
        bus0.in_immed   = immed;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                exp_err  = e;
                if (n >= 1) begin
                    sb.push_back('{word: w0, addr: exp_addr});
                    exp_addr = exp_addr + 16'h0001;
                end
                if (n == 2) begin
                    sb.push_back('{word: w1, addr: exp_addr});
                    exp_addr = exp_addr + 16'h0001;
                end
            end else begin
                @(posedge clk);
            end
            #1;
        end
        bus0.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: op %h never accepted", op);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("err", {15'h0, bus0.err}, {15'h0, exp_err});
            exp_err = 1'b0;
            if (prev_stall) begin
                checkOutput("stall_valid", {15'h0, bus0.out_valid}, 16'h0001);
                checkOutput("stall_word", bus0.out_word, prev_word);
                checkOutput("stall_addr", bus0.out_addr, prev_addr);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %h at %h, expected none", bus0.out_word, bus0.out_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("word", bus0.out_word, e.word);
                    checkOutput("addr", bus0.out_addr, e.addr);
                end
            end
            prev_stall = bus0.out_valid && !bus0.out_ready;
            prev_word  = bus0.out_word;
            prev_addr  = bus0.out_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus0.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] hold_addr;
        errors = 0; checks = 0;
        mon_en = 1'b0; rand_ready = 1'b0; exp_err = 1'b0; prev_stall = 1'b0;
        exp_addr = 16'h0000;
        vecs[0]  = '{8'h00, 16'h1234, 1'b0, 1, 16'h0000, 16'h0000};
        vecs[1]  = '{8'h0b, 16'h0000, 1'b0, 1, 16'h000b, 16'h0000};
        vecs[2]  = '{8'h10, 16'h0abc, 1'b0, 1, 16'h1abc, 16'h0000};
        vecs[3]  = '{8'h10, 16'h5abc, 1'b0, 2, 16'hb005, 16'h1abc};
        vecs[4]  = '{8'h0c, 16'hffff, 1'b0, 1, 16'h000c, 16'h0000};
        vecs[5]  = '{8'h40, 16'h1234, 1'b0, 2, 16'hb001, 16'h4234};
        vecs[6]  = '{8'h60, 16'h0fff, 1'b0, 1, 16'h6fff, 16'h0000};
        vecs[7]  = '{8'h70, 16'h8000, 1'b0, 2, 16'hb008, 16'h7000};
        vecs[8]  = '{8'h90, 16'h3456, 1'b1, 1, 16'h9456, 16'h0000};
        vecs[9]  = '{8'ha0, 16'h0001, 1'b0, 1, 16'ha001, 16'h0000};
        vecs[10] = '{8'hb0, 16'h7777, 1'b1, 1, 16'hb777, 16'h0000};
        vecs[11] = '{8'h0d, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[12] = '{8'h31, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[13] = '{8'h11, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[14] = '{8'hc0, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[15] = '{8'hf0, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[16] = '{8'h23, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[17] = '{8'h80, 16'h1007, 1'b1, 1, 16'h8007, 16'h0000};

        reset = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_op = 8'h00; bus0.in_immed = 16'h0000; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_op = 8'h00; bus1.in_immed = 16'h0000; bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {15'h0, bus0.out_valid}, 16'h0000);
        checkOutput("rst_word", bus0.out_word, 16'h0000);
        checkOutput("rst_addr", bus0.out_addr, 16'h0000);
        checkOutput("rst_err", {15'h0, bus0.err}, 16'h0000);
        checkOutput("rst_addr_hi", bus1.out_addr, 16'hfffe);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {15'h0, bus0.in_ready}, 16'h0001);
        @(posedge clk); #1;
        mon_en = 1'b1;

        $display("[TB] table pass, sink always ready");
        for (int i = 0; i < 18; i++)
            applyStimulus(vecs[i].op, vecs[i].immed, vecs[i].err, vecs[i].nwords, vecs[i].w0, vecs[i].w1);
        drain();

        $display("[TB] table pass, random sink backpressure");
        rand_ready = 1'b1;
        for (int i = 0; i < 18; i++)
            applyStimulus(vecs[i].op, vecs[i].immed, vecs[i].err, vecs[i].nwords, vecs[i].w0, vecs[i].w1);
        drain();
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bus0.out_ready = 1'b1;

        $display("[TB] prefix cycle blocks input");
        applyStimulus(8'h10, 16'h5abc, 1'b0, 2, 16'hb005, 16'h1abc);
        @(negedge clk);
        checkOutput("pre_in_ready", {15'h0, bus0.in_ready}, 16'h0000);
        checkOutput("pre_word", bus0.out_word, 16'hb005);
        drain();

        $display("[TB] stalled Jump with prefix");
        bus0.out_ready = 1'b0;
        hold_addr = exp_addr;
        applyStimulus(8'h50, 16'hf010, 1'b0, 2, 16'hb00f, 16'h5010);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_valid", {15'h0, bus0.out_valid}, 16'h0001);
            checkOutput("hold_word", bus0.out_word, 16'hb00f);
            checkOutput("hold_addr", bus0.out_addr, hold_addr);
            checkOutput("hold_in_ready", {15'h0, bus0.in_ready}, 16'h0000);
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        drain();

        $display("[TB] reset while in PRE");
        bus0.out_ready = 1'b0;
        applyStimulus(8'h40, 16'h2001, 1'b0, 2, 16'hb002, 16'h4001);
        @(negedge clk);
        checkOutput("rpre_word", bus0.out_word, 16'hb002);
        @(posedge clk); #1;
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr = 16'h0000;
        @(negedge clk);
        checkOutput("rpre_valid", {15'h0, bus0.out_valid}, 16'h0000);
        checkOutput("rpre_addr", bus0.out_addr, 16'h0000);
        checkOutput("rpre_err", {15'h0, bus0.err}, 16'h0000);
        bus0.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("rpre_no_main", {15'h0, bus0.out_valid}, 16'h0000);
        end

        $display("[TB] address wrap from 0xfffe, back-to-back");
        @(posedge clk); #1;
        bus1.in_valid = 1'b1; bus1.in_op = 8'h00;
        @(posedge clk); #1;
        bus1.in_op = 8'h01;
        @(negedge clk);
        checkOutput("wrap_w0", bus1.out_word, 16'h0000);
        checkOutput("wrap_a0", bus1.out_addr, 16'hfffe);
        checkOutput("wrap_rdy0", {15'h0, bus1.in_ready}, 16'h0001);
        @(posedge clk); #1;
        bus1.in_op = 8'h02;
        @(negedge clk);
        checkOutput("wrap_w1", bus1.out_word, 16'h0001);
        checkOutput("wrap_a1", bus1.out_addr, 16'hffff);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("wrap_w2", bus1.out_word, 16'h0002);
        checkOutput("wrap_a2", bus1.out_addr, 16'h0000);
        checkOutput("wrap_v2", {15'h0, bus1.out_valid}, 16'h0001);
        @(negedge clk);
        checkOutput("wrap_idle", {15'h0, bus1.out_valid}, 16'h0000);
        checkOutput("wrap_a3", bus1.out_addr, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming instruction encoder; the inverse of the processor's decode path, including Pre prefix handling.
- Accepts symbolic instructions as an 8-bit state-number opcode plus a 16-bit immediate.
- Emits the 16-bit instruction words the processor fetches, inserting a Pre word automatically when an immediate needs more than 12 bits.
- Each emitted word carries a main-memory address, so the output drives a memory-image writer or loader feeding mainmem.

Parameters:
- BASE_ADDR, 16'h0000, address assigned to the first emitted word after reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present on in_op/in_immed.
- in_ready  output  1  encoder accepts the instruction this cycle.
- in_op  input  8  opcode in state-number form {Opcode, sub-op}, e.g. 8'h00 Add, 8'h10 Push, 8'h50 Jump.
- in_immed  input  16  full immediate; ignored for sub-op class ops.
- out_valid  output  1  out_word/out_addr valid.
- out_ready  input  1  sink takes the word this cycle.
- out_word  output  16  encoded instruction word.
- out_addr  output  16  mainmem address for out_word.
- err  output  1  one-cycle pulse: illegal opcode, or immediate truncated.

Behaviour:
- Reset values: out_valid=0, out_word=0, out_addr=BASE_ADDR, err=0, state=EMPTY, pending word cleared. in_ready=1 in the cycle after reset.
- Class-0 ops 8'h00..8'h0c encode as {4'h0, 8'h00, in_op[3:0]}. in_immed is ignored and err is not raised.
- Immediate ops 8'h10, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'ha0, 8'hb0 encode as {in_op[7:4], in_immed[11:0]}.
- Prefixable ops are Push, Call, Jump, JumpF and JumpT.
  - If in_immed[15:12] != 0, emit Pre word {4'hb, 8'h00, in_immed[15:12]} first, then the main word.
  - This is two output words and two addresses.
- Get, Put, Pop and an explicit Pre op with in_immed[15:12] != 0: emit the truncated main word and pulse err.
- Any other opcode (8'h0d..8'h0f, low nibble nonzero with high nibble nonzero, 8'h2x, 8'h3x, 8'hcx..8'hfx) is illegal:
  - consumed, nothing emitted, err pulses;
  - the address does not advance.
- States:
  - EMPTY: out_valid=0.
  - PRE: out_word holds the Pre word; the main word waits in the pending register.
  - MAIN: out_word holds the main word.
- in_ready = (state==EMPTY) || (state==MAIN && out_ready). It is combinational, and is always 0 in PRE.
- Accept means in_valid && in_ready.
  - Legal op needing a prefix: go to PRE.
  - Other legal op: go to MAIN.
  - Illegal op: go to EMPTY.
  - Registered output is valid the next cycle; latency is one cycle.
- PRE with out_ready: go to MAIN with the pending word.
- MAIN with out_ready and no accept: go to EMPTY.
- MAIN with out_ready and accept: back-to-back, giving one word per cycle throughput.
- While out_valid && !out_ready, out_word and out_addr stay stable. No input is accepted except via the rule above.
- out_addr increments by 1 on every output handshake (out_valid && out_ready) and wraps from 16'hffff to 16'h0000 with no flag.
- err is registered: high exactly the cycle after the offending accept.
- Reset mid-operation, including in PRE with the main word pending: all pending output is discarded and the reset values apply the next cycle.

Test Plan:
- After reset, send Add (8'h00, immed 16'h1234) with out_ready=1 -> out_word 16'h0000 at addr 0x0000, err=0. Then send Sys 8'h0b -> 16'h000b at 0x0001.
- Push with immed 16'h0abc -> single word 16'h1abc. Push with immed 16'h5abc -> 16'hb005 at addr N, then 16'h1abc at N+1; in_ready=0 during the PRE cycle.
- Jump with immed 16'hf010 while out_ready is held 0 for 3 cycles -> 16'hb00f is held stable with out_valid=1, in_ready=0. On release, 16'h5010 follows.
- Illegal 8'h23, then Get 8'h80 with immed 16'h1007 -> err pulses twice; only 16'h8007 is emitted; the address advances by 1 in total.
- BASE_ADDR=16'hfffe, stream 3 class-0 ops with out_ready=1 -> addresses 0xfffe, 0xffff, 0x0000; one word per cycle back-to-back.
- Assert reset while in PRE (Call, immed 16'h2001) -> next cycle out_valid=0, out_addr=BASE_ADDR, and the main word 16'h4001 is never emitted.
